// File: rtl/hk_spi_bitbang_pkg.sv
// hk_spi_pkg: shared FSM states, command bits, register map and bit-bang decode for hk_spi_bitbang.
package hk_spi_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COMMAND = 2'd1, ADDRESS = 2'd2, DATA = 2'd3} state_t;
  localparam int CMD_WR = 7;
  localparam int CMD_RD = 6;
  localparam logic [7:0] ADDR_MFG_HI  = 8'h01;
  localparam logic [7:0] ADDR_MFG_LO  = 8'h02;
  localparam logic [7:0] ADDR_PROD    = 8'h03;
  localparam logic [7:0] ADDR_BITBANG = 8'h13;
  localparam int BB_XFER = 0;
  localparam int BB_EN   = 1;
  localparam int BB_RSTN = 2;
  localparam int BB_LOAD = 3;
  localparam int BB_CLK  = 4;
  localparam int BB_D1   = 5;
  localparam int BB_D2   = 6;
  typedef struct packed {
    logic xfer;
    logic clk;
    logic load;
    logic rstn;
    logic d1;
    logic d2;
  } bb_out_t;
  // With enable low the chain is parked: clock/load/data low, resetn high.
  function automatic bb_out_t bb_decode(input logic [7:0] r);
    bb_out_t o;
    o.xfer = r[BB_XFER];
    o.clk  = r[BB_EN] & r[BB_CLK];
    o.load = r[BB_EN] & r[BB_LOAD];
    o.rstn = ~r[BB_EN] | r[BB_RSTN];
    o.d1   = r[BB_EN] & r[BB_D1];
    o.d2   = r[BB_EN] & r[BB_D2];
    return o;
  endfunction
endpackage

// File: rtl/hk_spi_bitbang_if.sv
// hk_spi_bitbang_if: housekeeping SPI pin bundle; slave is the device side, master the host side.
interface hk_spi_bitbang_if;
  logic sck;
  logic csb;
  logic sdi;
  logic sdo;
  logic sdo_enb;
  modport slave (input sck, csb, sdi, output sdo, sdo_enb);
  modport master (output sck, csb, sdi, input sdo, sdo_enb);
endinterface

// File: rtl/hk_spi_bitbang_sync.sv
// hk_spi_sync: 2-flop synchroniser with rise/fall detect on the synchronised level.
module hk_spi_sync #(
  parameter logic RST = 1'b0
) (
  input  logic clock,
  input  logic resetb,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clock) s <= !resetb ? {3{RST}} : {s[1:0], d};
  assign q    = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/hk_spi_bitbang.sv
// hk_spi_bitbang: housekeeping SPI slave driving the GPIO config chain via register 0x13.
// Read support (sdo/sdo_enb) is built only when HKSPI_READ_EN is defined.
module hk_spi_bitbang
  import hk_spi_pkg::*;
#(
  parameter logic [7:0]  PRODUCT_ID = 8'h10,
  parameter logic [11:0] MFG_ID     = 12'h456
) (
  input  logic             clock,
  input  logic             resetb,
  hk_spi_bitbang_if.slave  spi,
  output logic             serial_xfer,
  output logic             serial_clock,
  output logic             serial_load,
  output logic             serial_resetn,
  output logic             serial_data_1,
  output logic             serial_data_2
);
  logic sck_s, sck_rise, sck_fall, csb_s, csb_rise, csb_fall, sdi_s, sdi_rise, sdi_fall;
  state_t state_q, state_n;
  logic [2:0] cnt;
  logic [6:0] sr;
  logic [7:0] addr, bb, byte_in;
  logic wr, byte_done;
  bb_out_t so;
  hk_spi_sync #(.RST(1'b0)) u_sck (.clock(clock), .resetb(resetb), .d(spi.sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall));
  hk_spi_sync #(.RST(1'b1)) u_csb (.clock(clock), .resetb(resetb), .d(spi.csb), .q(csb_s), .rise(csb_rise), .fall(csb_fall));
  hk_spi_sync #(.RST(1'b0)) u_sdi (.clock(clock), .resetb(resetb), .d(spi.sdi), .q(sdi_s), .rise(sdi_rise), .fall(sdi_fall));
  logic unused_sync;
  assign unused_sync = &{1'b0, sck_s, sck_fall, csb_rise, csb_fall, sdi_rise, sdi_fall};
  assign byte_in   = {sr, sdi_s};
  assign byte_done = sck_rise && cnt == 3'd7 && state_q != IDLE && !csb_s;
  always_comb state_n = csb_s ? IDLE : state_q == IDLE ? COMMAND :
                        byte_done ? (state_q == COMMAND ? ADDRESS : DATA) : state_q;
  always_ff @(posedge clock) state_q <= !resetb ? IDLE : state_n;
  // A partial byte is simply dropped when csb rises: the counter never reaches 8.
  always_ff @(posedge clock)
    if (!resetb || csb_s || state_q == IDLE) begin
      cnt <= '0;
      sr  <= '0;
    end else if (sck_rise) begin
      cnt <= cnt + 3'd1;
      sr  <= byte_in[6:0];
    end
  always_ff @(posedge clock)
    if (!resetb) begin
      wr   <= 1'b0;
      addr <= '0;
      bb   <= '0;
      so   <= bb_decode(8'h00);
    end else if (byte_done) begin
      if (state_q == COMMAND) wr <= byte_in[CMD_WR];
      if (state_q == ADDRESS) addr <= byte_in;
      if (state_q == DATA) begin
        addr <= addr + 8'd1;
        if (wr && addr == ADDR_BITBANG) begin
          bb <= {1'b0, byte_in[6:0]};
          so <= bb_decode(byte_in);
        end
      end
    end
  assign serial_xfer   = so.xfer;
  assign serial_clock  = so.clk;
  assign serial_load   = so.load;
  assign serial_resetn = so.rstn;
  assign serial_data_1 = so.d1;
  assign serial_data_2 = so.d2;
`ifdef HKSPI_READ_EN
  logic rd, armed;
  logic [7:0] osr;
  function automatic logic [7:0] rdata(input logic [7:0] a, input logic [7:0] r);
    return a == ADDR_MFG_HI ? {4'h0, MFG_ID[11:8]} : a == ADDR_MFG_LO ? MFG_ID[7:0] :
           a == ADDR_PROD ? PRODUCT_ID : a == ADDR_BITBANG ? r : 8'h00;
  endfunction
  // Read data is captured at the 8th rise, before any write of the same byte lands.
  always_ff @(posedge clock)
    if (!resetb || csb_s) begin
      rd          <= 1'b0;
      armed       <= 1'b0;
      osr         <= '0;
      spi.sdo     <= 1'b0;
      spi.sdo_enb <= 1'b1;
    end else if (byte_done) begin
      if (state_q == COMMAND) rd <= byte_in[CMD_RD];
      else if (rd) begin
        osr   <= rdata(state_q == ADDRESS ? byte_in : addr + 8'd1, bb);
        armed <= 1'b1;
      end
    end else if (sck_fall && armed) begin
      spi.sdo     <= osr[7];
      osr         <= {osr[6:0], 1'b0};
      spi.sdo_enb <= 1'b0;
    end
`else
  logic unused_id;
  assign unused_id   = ^{PRODUCT_ID, MFG_ID};
  assign spi.sdo     = 1'b0;
  assign spi.sdo_enb = 1'b1;
`endif
endmodule

// File: tb/tb_hk_spi_bitbang.sv
// tb_hk_spi_bitbang: directed self-checking bench for hk_spi_bitbang.
module tb_hk_spi_bitbang;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic serial_xfer, serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2;
  int n_cmp = 0, n_bad = 0;
  hk_spi_bitbang_if spi();
  hk_spi_bitbang dut (
    .clock(clk), .resetb(resetb), .spi(spi),
    .serial_xfer(serial_xfer), .serial_clock(serial_clock), .serial_load(serial_load),
    .serial_resetn(serial_resetn), .serial_data_1(serial_data_1), .serial_data_2(serial_data_2)
  );
  always #5 clk = ~clk;
  // Reference model of the GPIO config chain: shifts data_1 on serial_clock rise.
  logic [12:0] ref_sr = '0;
  int n_sclk = 0, n_load = 0;
  logic p_sclk = 1'b0, p_load = 1'b0;
  always @(negedge clk) begin
    p_sclk <= serial_clock;
    p_load <= serial_load;
    if (serial_clock && !p_sclk) begin
      ref_sr <= {ref_sr[11:0], serial_data_1};
      n_sclk <= n_sclk + 1;
    end
    if (serial_load && !p_load) n_load <= n_load + 1;
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic spi_bit(input logic b, output logic r);
    spi.sdi = b;
    repeat (5) @(negedge clk);
    r = spi.sdo;
    spi.sck = 1'b1;
    repeat (5) @(negedge clk);
    spi.sck = 1'b0;
  endtask
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask
  task automatic end_x();
    repeat (5) @(negedge clk);
    spi.csb = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  task automatic wr13(input logic [7:0] v);
    logic [7:0] d;
    spi.csb = 1'b0;
    spi_byte(8'h80, d);
    spi_byte(8'h13, d);
    spi_byte(v, d);
    end_x();
  endtask
  task automatic chk_outs(input string tag, input logic [5:0] exp);
    chk({tag, ".xfer"}, 16'(serial_xfer), 16'(exp[5]));
    chk({tag, ".clock"}, 16'(serial_clock), 16'(exp[4]));
    chk({tag, ".load"}, 16'(serial_load), 16'(exp[3]));
    chk({tag, ".resetn"}, 16'(serial_resetn), 16'(exp[2]));
    chk({tag, ".data_1"}, 16'(serial_data_1), 16'(exp[1]));
    chk({tag, ".data_2"}, 16'(serial_data_2), 16'(exp[0]));
  endtask
  initial begin
    logic [7:0] d, r0, r1, r2;
    logic b;
    logic [12:0] pat;
`ifdef HKSPI_READ_EN
    logic rd_en = 1'b1;
`else
    logic rd_en = 1'b0;
`endif
    spi.sck = 1'b0;
    spi.csb = 1'b1;
    spi.sdi = 1'b0;
    repeat (4) @(negedge clk);
    resetb = 1'b1;
    repeat (4) @(negedge clk);
    // {xfer, clock, load, resetn, data_1, data_2}
    chk_outs("reset", 6'b000100);
    chk("reset.sdo", 16'(spi.sdo), 16'h0);
    chk("reset.sdo_enb", 16'(spi.sdo_enb), 16'h1);
    // Abort after 5 bits of 0xFF
    spi.csb = 1'b0;
    spi_byte(8'h80, d);
    spi_byte(8'h13, d);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    end_x();
    chk_outs("abort", 6'b000100);
    // Write 0x66 with an edge-exact latency check on the 8th bit
    spi.csb = 1'b0;
    spi_byte(8'h80, d);
    spi_byte(8'h13, d);
    pat = 13'h0066;
    for (int i = 7; i >= 1; i--) spi_bit(pat[i], b);
    spi.sdi = 1'b0;
    repeat (5) @(negedge clk);
    spi.sck = 1'b1;
    repeat (2) @(negedge clk);
    chk("latency.before", 16'(serial_data_1), 16'h0);
    @(negedge clk);
    chk("latency.after", 16'(serial_data_1), 16'h1);
    repeat (2) @(negedge clk);
    spi.sck = 1'b0;
    end_x();
    chk_outs("wr66", 6'b000111);
    // Bit-bang 0x1809 into the chain, then pulse load
    pat = 13'h1809;
    for (int i = 12; i >= 0; i--) begin
      wr13(pat[i] ? 8'h66 : 8'h06);
      wr13(pat[i] ? 8'h76 : 8'h16);
    end
    wr13(8'h0e);
    wr13(8'h06);
    chk("chain.value", 16'(ref_sr), 16'h1809);
    chk("chain.clocks", 16'(n_sclk), 16'd13);
    chk("chain.loads", 16'(n_load), 16'd1);
    // Enable off parks the chain
    wr13(8'h04);
    chk_outs("wr04", 6'b000100);
    wr13(8'h03);
    chk_outs("wr03", 6'b100000);
    // Reads: 0x01, 0x02, 0x03 streamed, then 0x13
    spi.csb = 1'b0;
    spi_byte(8'h40, d);
    spi_byte(8'h01, d);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    spi_byte(8'h00, r2);
    chk("read.enb_active", 16'(spi.sdo_enb), rd_en ? 16'h0 : 16'h1);
    end_x();
    chk("read.mfg_hi", 16'(r0), rd_en ? 16'h04 : 16'h00);
    chk("read.mfg_lo", 16'(r1), rd_en ? 16'h56 : 16'h00);
    chk("read.prod", 16'(r2), rd_en ? 16'h10 : 16'h00);
    chk("read.enb_idle", 16'(spi.sdo_enb), 16'h1);
    spi.csb = 1'b0;
    spi_byte(8'h40, d);
    spi_byte(8'h13, d);
    spi_byte(8'h00, r0);
    end_x();
    chk("read.bitbang", 16'(r0), rd_en ? 16'h03 : 16'h00);
    chk_outs("read.noeffect", 6'b100000);
    // Reset mid-stream
    spi.csb = 1'b0;
    spi_byte(8'h80, d);
    spi_byte(8'h13, d);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    resetb = 1'b0;
    spi.csb = 1'b1;
    repeat (3) @(negedge clk);
    chk_outs("midreset", 6'b000100);
    chk("midreset.sdo_enb", 16'(spi.sdo_enb), 16'h1);
    resetb = 1'b1;
    repeat (5) @(negedge clk);
    wr13(8'h66);
    chk_outs("post_reset_wr66", 6'b000111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
